// File: rtl/gerenciador_temporizadores_if.sv
// Command/status bundle between the quiz control FSM (master) and the timing scheduler (slave).
interface gerenciador_temporizadores_if #(
    parameter int CW = 16
);
    logic          pausa;
    logic          zera_timeout;
    logic          conta_timeout;
    logic          zera_timer_resultado;
    logic          conta_timer_resultado;
    logic          zera_tempo_de_jogo;
    logic          mostra_tempo_de_jogo;
    logic          deu_timeout;
    logic          fim_timer_resultado;
    logic [CW-1:0] tempo_restante;
    logic [CW-1:0] tempo_de_jogo;
    logic          tick;
    logic [3:0]    db_estado;

    modport master (
        output pausa, zera_timeout, conta_timeout, zera_timer_resultado,
               conta_timer_resultado, zera_tempo_de_jogo, mostra_tempo_de_jogo,
        input  deu_timeout, fim_timer_resultado, tempo_restante, tempo_de_jogo,
               tick, db_estado
    );

    modport slave (
        input  pausa, zera_timeout, conta_timeout, zera_timer_resultado,
               conta_timer_resultado, zera_tempo_de_jogo, mostra_tempo_de_jogo,
        output deu_timeout, fim_timer_resultado, tempo_restante, tempo_de_jogo,
               tick, db_estado
    );
endinterface

// File: rtl/gerenciador_temporizadores.sv
// Quiz timing scheduler: answer-timeout and result-hold channels plus the game clock,
// all advancing on one shared free-running tick prescaler.
module gerenciador_temporizadores #(
    parameter int TICK_DIV      = 50000,
    parameter int TIMEOUT_TICKS = 5000,
    parameter int RESULT_TICKS  = 2000,
    parameter int SEC_TICKS     = 1000,
    parameter int CW            = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    gerenciador_temporizadores_if.slave   bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;

    localparam logic [PW-1:0] PRE_MAX       = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SUB_MAX       = SW'(SEC_TICKS - 1);
    localparam logic [CW-1:0] LIM_TIMEOUT   = CW'(TIMEOUT_TICKS);
    localparam logic [CW-1:0] LIM_RESULTADO = CW'(RESULT_TICKS);

    localparam logic [1:0] PARADO   = 2'b00;
    localparam logic [1:0] CONTANDO = 2'b01;
    localparam logic [1:0] EXPIRADO = 2'b10;

    // Shared channel transition: returns {next state, next count}.
    function automatic logic [CW+1:0] proximo_canal(
        input logic [1:0]    estado,
        input logic [CW-1:0] contagem,
        input logic          zera,
        input logic          conta,
        input logic          avanca,
        input logic [CW-1:0] limite
    );
        logic [1:0]    estado_d;
        logic [CW-1:0] contagem_d;
        estado_d   = estado;
        contagem_d = contagem;
        if (zera) begin
            estado_d   = PARADO;
            contagem_d = '0;
        end else begin
            case (estado)
                PARADO:   if (conta) estado_d = CONTANDO;
                CONTANDO: begin
                    if (!conta) begin
                        estado_d = PARADO;
                    end else if (avanca) begin
                        contagem_d = contagem + CW'(1);
                        if (contagem_d == limite) estado_d = EXPIRADO;
                    end
                end
                EXPIRADO: estado_d = EXPIRADO;
                default:  estado_d = PARADO;
            endcase
        end
        return {estado_d, contagem_d};
    endfunction

    function automatic logic [CW-1:0] incr_saturado(input logic [CW-1:0] valor);
        return (&valor) ? valor : valor + CW'(1);
    endfunction

    logic [PW-1:0] prescaler;
    logic          tick;
    logic          avanca;

    logic [1:0]    estado_to, estado_to_d;
    logic [1:0]    estado_res, estado_res_d;
    logic [CW-1:0] cont_to, cont_to_d;
    logic [CW-1:0] cont_res, cont_res_d;

    logic [SW-1:0] sub_seg;
    logic [CW-1:0] segundos;

    // Prescaler is never realigned to channel starts, hence up to one tick of early expiry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                  prescaler <= '0;
        else if (prescaler == PRE_MAX) prescaler <= '0;
        else                        prescaler <= prescaler + PW'(1);
    end

    assign tick   = (prescaler == PRE_MAX);
    assign avanca = tick & ~bus.pausa;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_to  <= PARADO;
            estado_res <= PARADO;
            cont_to    <= '0;
            cont_res   <= '0;
        end else begin
            estado_to  <= estado_to_d;
            estado_res <= estado_res_d;
            cont_to    <= cont_to_d;
            cont_res   <= cont_res_d;
        end
    end

    always_comb begin
        {estado_to_d, cont_to_d} = proximo_canal(estado_to, cont_to, bus.zera_timeout,
                                                 bus.conta_timeout, avanca, LIM_TIMEOUT);
        {estado_res_d, cont_res_d} = proximo_canal(estado_res, cont_res, bus.zera_timer_resultado,
                                                   bus.conta_timer_resultado, avanca, LIM_RESULTADO);
    end

    // Flags are Moore outputs straight from the state registers.
    always_comb begin
        bus.deu_timeout         = (estado_to == EXPIRADO);
        bus.fim_timer_resultado = (estado_res == EXPIRADO);
        bus.tempo_restante      = LIM_TIMEOUT - cont_to;
        bus.tempo_de_jogo       = segundos;
        bus.tick                = tick;
        bus.db_estado           = {estado_to, estado_res};
    end

    // Game clock: mostra freezes both counters so the displayed value is stable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sub_seg  <= '0;
            segundos <= '0;
        end else if (bus.zera_tempo_de_jogo) begin
            sub_seg  <= '0;
            segundos <= '0;
        end else if (avanca && !bus.mostra_tempo_de_jogo) begin
            if (sub_seg == SUB_MAX) begin
                sub_seg  <= '0;
                segundos <= incr_saturado(segundos);
            end else begin
                sub_seg <= sub_seg + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_gerenciador_temporizadores.sv
// Directed-vector bench for the quiz timing scheduler (TICK_DIV=4, TIMEOUT=5, RESULT=3, SEC=2).
module tb_gerenciador_temporizadores;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    gerenciador_temporizadores_if #(.CW(16)) bus ();

    gerenciador_temporizadores #(
        .TICK_DIV(4), .TIMEOUT_TICKS(5), .RESULT_TICKS(3), .SEC_TICKS(2), .CW(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pausa = 0; bus.zera_timeout = 0; bus.conta_timeout = 0;
        bus.zera_timer_resultado = 0; bus.conta_timer_resultado = 0;
        bus.zera_tempo_de_jogo = 0; bus.mostra_tempo_de_jogo = 0;
    endtask

    // After this, the next rising edge is edge 1 and the prescaler is 0.
    task automatic do_reset();
        idle_inputs();
        reset = 1;
        @(posedge clock);
        #1;
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.conta_timeout = 1;
        reset = 0;
        step(9);
        reset = 1;
        #2;
        vectors++; if (bus.deu_timeout !== 1'b0) begin miscompares++; $display("FAIL rst_deu_timeout: got %0b expected 0", bus.deu_timeout); end
        vectors++; if (bus.fim_timer_resultado !== 1'b0) begin miscompares++; $display("FAIL rst_fim_resultado: got %0b expected 0", bus.fim_timer_resultado); end
        vectors++; if (bus.tempo_restante !== 16'd5) begin miscompares++; $display("FAIL rst_tempo_restante: got %0d expected 5", bus.tempo_restante); end
        vectors++; if (bus.tempo_de_jogo !== 16'd0) begin miscompares++; $display("FAIL rst_tempo_de_jogo: got %0d expected 0", bus.tempo_de_jogo); end
        vectors++; if (bus.tick !== 1'b0) begin miscompares++; $display("FAIL rst_tick: got %0b expected 0", bus.tick); end
        vectors++; if (bus.db_estado !== 4'b0000) begin miscompares++; $display("FAIL rst_db_estado: got %b expected 0000", bus.db_estado); end
    endtask

    task automatic test_timeout_count();
        int exp_tr;
        do_reset();
        bus.conta_timeout = 1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            exp_tr = 5 - k / 4;
            vectors++; if (bus.tempo_restante !== 16'(exp_tr)) begin miscompares++; $display("FAIL to_restante edge %0d: got %0d expected %0d", k, bus.tempo_restante, exp_tr); end
            vectors++; if (bus.deu_timeout !== (k == 20)) begin miscompares++; $display("FAIL to_deu edge %0d: got %0b expected %0b", k, bus.deu_timeout, (k == 20)); end
            vectors++; if (bus.tick !== ((k % 4) == 3)) begin miscompares++; $display("FAIL to_tick edge %0d: got %0b expected %0b", k, bus.tick, ((k % 4) == 3)); end
        end
        vectors++; if (bus.db_estado[3:2] !== 2'b10) begin miscompares++; $display("FAIL to_db_expirado: got %b expected 10", bus.db_estado[3:2]); end
    endtask

    // Continues from the expired timeout left by test_timeout_count (edge 20).
    task automatic test_zera_expired();
        bus.zera_timeout = 1;
        step(1);
        bus.zera_timeout = 0;
        vectors++; if (bus.deu_timeout !== 1'b0) begin miscompares++; $display("FAIL zx_deu: got %0b expected 0", bus.deu_timeout); end
        vectors++; if (bus.tempo_restante !== 16'd5) begin miscompares++; $display("FAIL zx_restante: got %0d expected 5", bus.tempo_restante); end
        vectors++; if (bus.db_estado[3:2] !== 2'b00) begin miscompares++; $display("FAIL zx_db_parado: got %b expected 00", bus.db_estado[3:2]); end
        step(1);
        vectors++; if (bus.db_estado[3:2] !== 2'b01) begin miscompares++; $display("FAIL zx_db_contando: got %b expected 01", bus.db_estado[3:2]); end
        step(1);
        vectors++; if (bus.tempo_restante !== 16'd5) begin miscompares++; $display("FAIL zx_restante_e23: got %0d expected 5", bus.tempo_restante); end
        step(1);
        vectors++; if (bus.tempo_restante !== 16'd4) begin miscompares++; $display("FAIL zx_restante_e24: got %0d expected 4", bus.tempo_restante); end
    endtask

    task automatic test_result_resume();
        do_reset();
        bus.conta_timer_resultado = 1;
        step(8);
        vectors++; if (bus.db_estado[1:0] !== 2'b01) begin miscompares++; $display("FAIL rr_db_contando: got %b expected 01", bus.db_estado[1:0]); end
        vectors++; if (bus.fim_timer_resultado !== 1'b0) begin miscompares++; $display("FAIL rr_fim_e8: got %0b expected 0", bus.fim_timer_resultado); end
        bus.conta_timer_resultado = 0;
        step(1);
        vectors++; if (bus.db_estado[1:0] !== 2'b00) begin miscompares++; $display("FAIL rr_db_parado: got %b expected 00", bus.db_estado[1:0]); end
        step(9);
        vectors++; if (bus.fim_timer_resultado !== 1'b0) begin miscompares++; $display("FAIL rr_fim_e18: got %0b expected 0", bus.fim_timer_resultado); end
        bus.conta_timer_resultado = 1;
        step(1);
        vectors++; if (bus.fim_timer_resultado !== 1'b0) begin miscompares++; $display("FAIL rr_fim_e19: got %0b expected 0", bus.fim_timer_resultado); end
        step(1);
        vectors++; if (bus.fim_timer_resultado !== 1'b1) begin miscompares++; $display("FAIL rr_fim_e20: got %0b expected 1", bus.fim_timer_resultado); end
        vectors++; if (bus.db_estado[1:0] !== 2'b10) begin miscompares++; $display("FAIL rr_db_expirado: got %b expected 10", bus.db_estado[1:0]); end
        bus.conta_timer_resultado = 0;
        step(3);
        vectors++; if (bus.fim_timer_resultado !== 1'b1) begin miscompares++; $display("FAIL rr_fim_sticky: got %0b expected 1", bus.fim_timer_resultado); end
    endtask

    task automatic test_pausa();
        do_reset();
        bus.conta_timeout = 1;
        bus.zera_tempo_de_jogo = 1;
        step(1);
        bus.zera_tempo_de_jogo = 0;
        step(4);
        bus.pausa = 1;
        step(7);
        bus.pausa = 0;
        vectors++; if (bus.tempo_restante !== 16'd4) begin miscompares++; $display("FAIL pa_restante_e12: got %0d expected 4", bus.tempo_restante); end
        step(15);
        vectors++; if (bus.deu_timeout !== 1'b0) begin miscompares++; $display("FAIL pa_deu_e27: got %0b expected 0", bus.deu_timeout); end
        vectors++; if (bus.tempo_restante !== 16'd1) begin miscompares++; $display("FAIL pa_restante_e27: got %0d expected 1", bus.tempo_restante); end
        step(1);
        vectors++; if (bus.deu_timeout !== 1'b1) begin miscompares++; $display("FAIL pa_deu_e28: got %0b expected 1", bus.deu_timeout); end
        vectors++; if (bus.tempo_restante !== 16'd0) begin miscompares++; $display("FAIL pa_restante_e28: got %0d expected 0", bus.tempo_restante); end
        vectors++; if (bus.tempo_de_jogo !== 16'd2) begin miscompares++; $display("FAIL pa_tempo_de_jogo: got %0d expected 2", bus.tempo_de_jogo); end
    endtask

    task automatic test_zera_on_expiry();
        do_reset();
        bus.conta_timeout = 1;
        step(19);
        bus.zera_timeout = 1;
        step(1);
        bus.zera_timeout = 0;
        bus.conta_timeout = 0;
        vectors++; if (bus.deu_timeout !== 1'b0) begin miscompares++; $display("FAIL ze_deu_e20: got %0b expected 0", bus.deu_timeout); end
        vectors++; if (bus.db_estado[3:2] !== 2'b00) begin miscompares++; $display("FAIL ze_db: got %b expected 00", bus.db_estado[3:2]); end
        vectors++; if (bus.tempo_restante !== 16'd5) begin miscompares++; $display("FAIL ze_restante: got %0d expected 5", bus.tempo_restante); end
        for (int k = 0; k < 8; k++) begin
            step(1);
            vectors++; if (bus.deu_timeout !== 1'b0) begin miscompares++; $display("FAIL ze_deu_after %0d: got %0b expected 0", k, bus.deu_timeout); end
        end
    endtask

    task automatic test_game_clock();
        do_reset();
        bus.zera_tempo_de_jogo = 1;
        step(1);
        bus.zera_tempo_de_jogo = 0;
        step(6);
        vectors++; if (bus.tempo_de_jogo !== 16'd0) begin miscompares++; $display("FAIL gc_e7: got %0d expected 0", bus.tempo_de_jogo); end
        step(1);
        vectors++; if (bus.tempo_de_jogo !== 16'd1) begin miscompares++; $display("FAIL gc_e8: got %0d expected 1", bus.tempo_de_jogo); end
        step(33);
        vectors++; if (bus.tempo_de_jogo !== 16'd5) begin miscompares++; $display("FAIL gc_e41: got %0d expected 5", bus.tempo_de_jogo); end
        bus.mostra_tempo_de_jogo = 1;
        for (int k = 0; k < 20; k++) begin
            step(1);
            vectors++; if (bus.tempo_de_jogo !== 16'd5) begin miscompares++; $display("FAIL gc_hold %0d: got %0d expected 5", k, bus.tempo_de_jogo); end
        end
        bus.zera_tempo_de_jogo = 1;
        step(1);
        bus.zera_tempo_de_jogo = 0;
        vectors++; if (bus.tempo_de_jogo !== 16'd0) begin miscompares++; $display("FAIL gc_zera_mostra: got %0d expected 0", bus.tempo_de_jogo); end
        step(8);
        vectors++; if (bus.tempo_de_jogo !== 16'd0) begin miscompares++; $display("FAIL gc_zera_hold: got %0d expected 0", bus.tempo_de_jogo); end
        bus.mostra_tempo_de_jogo = 0;
        bus.conta_timeout = 1;
        step(12);
        vectors++; if (bus.tempo_de_jogo !== 16'd1) begin miscompares++; $display("FAIL gc_e82: got %0d expected 1", bus.tempo_de_jogo); end
        vectors++; if (bus.tempo_restante !== 16'd2) begin miscompares++; $display("FAIL gc_restante_e82: got %0d expected 2", bus.tempo_restante); end
        #2;
        reset = 1;
        #1;
        vectors++; if (bus.tempo_de_jogo !== 16'd0) begin miscompares++; $display("FAIL gc_async_reset: got %0d expected 0", bus.tempo_de_jogo); end
        vectors++; if (bus.tempo_restante !== 16'd5) begin miscompares++; $display("FAIL gc_reset_restante: got %0d expected 5", bus.tempo_restante); end
        vectors++; if (bus.db_estado !== 4'b0000) begin miscompares++; $display("FAIL gc_reset_db: got %b expected 0000", bus.db_estado); end
        idle_inputs();
        step(1);
        reset = 0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_timeout_count();
        test_zera_expired();
        test_result_resume();
        test_pausa();
        test_zera_on_expiry();
        test_game_clock();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
